// File: rtl/dcache_ctrl_param.sv
// ============================================================================
// Module  : dcache_ctrl_param
// Brief   : Direct-mapped, write-back, write-allocate data cache controller
//           with a request/acknowledge block memory port. Optional hit/miss
//           statistics are enabled with the CACHE_STATS_EN macro.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int OFF_W  = 1,
    parameter int IDX_W  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cpu_read,
    input  logic                           cpu_write,
    input  logic [ADDR_W-1:0]              cpu_addr,
    input  logic [DATA_W-1:0]              cpu_wdata,
    output logic [DATA_W-1:0]              cpu_rdata,
    output logic                           cpu_busy,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-OFF_W-1:0]        mem_addr,
    output logic [(DATA_W << OFF_W)-1:0]   mem_wdata,
    input  logic [(DATA_W << OFF_W)-1:0]   mem_rdata,
    input  logic                           mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]                    hit_count,
    output logic [15:0]                    miss_count
`endif
);

    localparam int BLK_W = DATA_W << OFF_W;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [BLK_W-1:0] data_arr [LINES];
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;

    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic [BLK_W-1:0] line;
    logic             hit;
    logic             req;
    logic             write_hit;
    logic             fill_done;

    assign cpu_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign idx       = cpu_addr[OFF_W +: IDX_W];
    assign off       = cpu_addr[OFF_W-1:0];
    assign line      = data_arr[idx];
    assign hit       = valid[idx] && (tag_arr[idx] == cpu_tag);
    assign req       = cpu_read ^ cpu_write;
    assign write_hit = (state == IDLE) && req && hit && cpu_write;
    assign fill_done = (state == ALLOCATE) && mem_ack;

    assign cpu_rdata = line[int'(off)*DATA_W +: DATA_W];
    assign mem_wdata = line;
    // Write-back targets the victim's block; every other state addresses the CPU's block.
    assign mem_addr  = (state == WRITEBACK) ? {tag_arr[idx], idx} : cpu_addr[ADDR_W-1:OFF_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cpu_busy = 1'b0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    cpu_busy = 1'b1;
                    state_nx = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                cpu_busy = 1'b1;
                if (mem_ack) begin
                    state_nx = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_busy = 1'b1;
                if (mem_ack) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (reset) begin
            cpu_busy = 1'b0;
        end
    end

    // Memory requests are registered so they drop the cycle after mem_ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            dirty     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            mem_read  <= (state_nx == ALLOCATE);
            mem_write <= (state_nx == WRITEBACK);
            if (write_hit) begin
                dirty[idx] <= 1'b1;
            end
            if ((state == WRITEBACK) && mem_ack) begin
                dirty[idx] <= 1'b0;
            end
            if (fill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_hit) begin
            data_arr[idx][int'(off)*DATA_W +: DATA_W] <= cpu_wdata;
        end
        if (fill_done) begin
            data_arr[idx] <= mem_rdata;
            tag_arr[idx]  <= cpu_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic just_filled;

    // The hit that completes a miss right after the fill is not a new access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            just_filled <= 1'b0;
            hit_count   <= 16'd0;
            miss_count  <= 16'd0;
        end else begin
            just_filled <= fill_done;
            if ((state == IDLE) && req && hit && !just_filled && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if ((state == IDLE) && req && !hit && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/dcache_ctrl_param.md
Name: dcache_ctrl_param

Overview:
Parametrised direct-mapped, write-back, write-allocate data cache controller. It sits between the control unit's load/store port and the slow block-wide data memory.
Replaces the fixed 8-line, 2-byte-block cache with a clocked FSM and an explicit request/acknowledge memory handshake. Geometry is configurable, and there is optional hit/miss statistics.

Parameters:
ADDR_W, 8, CPU byte-address width
DATA_W, 8, CPU word width in bits
OFF_W, 1, log2(words per block); block width BLK_W = DATA_W << OFF_W
IDX_W, 3, log2(lines); tag width TAG_W = ADDR_W - IDX_W - OFF_W (must be >= 1)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high
cpu_read  in  1  load request, level, held until cpu_busy low
cpu_write  in  1  store request, level, held until cpu_busy low
cpu_addr  in  ADDR_W  {tag, index, offset}
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, valid when cpu_read and !cpu_busy
cpu_busy  out  1  stall to CPU (gates PC/regfile write)
mem_read  out  1  block fill request
mem_write  out  1  block write-back request
mem_addr  out  ADDR_W-OFF_W  block address
mem_wdata  out  BLK_W  write-back block, word 0 in LSBs
mem_rdata  in  BLK_W  fill block, sampled when mem_ack high
mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Storage: data array of 2^IDX_W blocks; per-line valid, dirty and tag registers.
- Reset (async): state=IDLE; all valid and dirty cleared; mem_read=mem_write=0; cpu_busy=0.
  - Data and tag arrays are not cleared.
  - Reset asserted mid-WRITEBACK or mid-ALLOCATE aborts the transfer immediately; memory contents are the memory's responsibility.
- hit = valid[idx] && tag[idx]==cpu_tag (combinational).
- Request = cpu_read XOR cpu_write.
  - Both high, or both low, is a no-op: cpu_busy=0 and no state change.
- IDLE:
  - Read hit: cpu_busy=0 in the same cycle; cpu_rdata = word[offset] of the line (combinational). Zero-cycle stall.
  - Write hit: cpu_busy=0; word[offset] <= cpu_wdata and dirty[idx] <= 1 at the next posedge.
  - Miss: cpu_busy=1 combinationally. Next state is WRITEBACK if valid&&dirty, else ALLOCATE.
- WRITEBACK:
  - Outputs: mem_write=1 (registered, asserted from the cycle after entry); mem_addr={old tag, idx}; mem_wdata=line.
  - Held stable until mem_ack.
  - On mem_ack: mem_write<=0, dirty[idx]<=0, go to ALLOCATE.
- ALLOCATE:
  - Outputs: mem_read=1; mem_addr=cpu_addr[ADDR_W-1:OFF_W].
  - Held until mem_ack.
  - On mem_ack: line<=mem_rdata, tag<=cpu_tag, valid<=1, dirty<=0, mem_read<=0, go to IDLE.
  - The re-evaluated request then hits; a write-allocate completes as a write hit that cycle.
- cpu_busy=1 throughout WRITEBACK and ALLOCATE.
- mem_read and mem_write are never high together. Requests drop the cycle after mem_ack.
- mem_ack while in IDLE is ignored.
- Miss latency = (writeback ? Lw+1 : 0) + Lr+1 cycles, where Lw and Lr are the memory ack latencies.
- CPU inputs must stay stable while busy. The controller latches nothing from the CPU except through state.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Both reset to 0 and saturate at 0xFFFF.
  - hit_count increments once per completed access that hit in IDLE on first evaluation.
  - miss_count increments once per access entering WRITEBACK/ALLOCATE.
  - The post-fill re-hit is not counted as a hit.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, then read 0x23 (tag 2, idx 1, off 1) -> cpu_busy=1; ALLOCATE with mem_addr=0x11. Memory acks after 5 cycles with mem_rdata=0x4D07 -> cpu_rdata=0x4D, busy low; no mem_write seen.
2. Write 0x22 data 0x99 after step 1 -> zero-stall hit, dirty[1]=1. Then read 0x22 -> 0x99, busy never high.
3. Read 0x43 (tag 4, idx 1) after step 2 -> WRITEBACK with mem_addr=0x11 and mem_wdata=0x4D99, then ALLOCATE with mem_addr=0x21, then returns filled word; dirty[1]=0.
4. cpu_read and cpu_write both high on a miss address -> cpu_busy=0, no mem request, state IDLE.
5. Assert reset 2 cycles into ALLOCATE -> mem_read drops without waiting for clk; then re-read 0x23 -> miss (valid cleared).
6. With CACHE_STATS_EN, run steps 1-3 -> hit_count=2, miss_count=2. Force 65536 hits -> hit_count holds at 0xFFFF.
